// File: rtl/pixel_unpacker.sv
// AXI4-Stream slave that unpacks 24bpp pixels (4 pixels per 3 x 32-bit words) into one
// {r,g,b} pixel per output handshake, with frame coordinates and framing error flags.
module pixel_unpacker #(
    parameter int unsigned SCREEN_WIDTH  = 640,
    parameter int unsigned SCREEN_HEIGHT = 480,
    parameter int unsigned COLOR_WIDTH   = 8
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic [31:0]            in_stream_tdata,
    input  logic [3:0]             in_stream_tkeep,
    input  logic                   in_stream_tlast,
    input  logic                   in_stream_tuser,
    input  logic                   in_stream_tvalid,
    output logic                   in_stream_tready,
    output logic [COLOR_WIDTH-1:0] pix_r,
    output logic [COLOR_WIDTH-1:0] pix_g,
    output logic [COLOR_WIDTH-1:0] pix_b,
    output logic [15:0]            pix_x,
    output logic [15:0]            pix_y,
    output logic                   pix_sof,
    output logic                   pix_eol,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic                   frame_done,
    output logic                   err_sof,
    output logic                   err_line
);

    typedef enum logic [1:0] {PH0, PH1, PH2, EMIT3} state_t;

    localparam logic [15:0] X_LAST = 16'(SCREEN_WIDTH - 1);
    localparam logic [15:0] X_PRE  = 16'(SCREEN_WIDTH - 2);
    localparam logic [15:0] Y_LAST = 16'(SCREEN_HEIGHT - 1);

    state_t      state;
    state_t      dec;
    logic [15:0] carry;
    logic [23:0] p3;
    logic        p3_close;
    logic [15:0] nx;
    logic [15:0] ny;

    logic        out_free;
    logic        accept;
    logic        load;
    logic [23:0] ld_data;
    logic        ld_close;
    logic [15:0] ld_x;
    logic [15:0] ld_y;
    logic        line_end;
    logic        tlast_err;
    logic        sof_err;
    logic        unused_tkeep;

    assign unused_tkeep = ^in_stream_tkeep;

    always_comb begin
        out_free         = !pix_valid || pix_ready;
        in_stream_tready = !areset && (state != EMIT3) && out_free;
        accept           = in_stream_tvalid && in_stream_tready;
        // A tuser word always restarts the group, whatever phase we were in.
        dec              = in_stream_tuser ? PH0 : state;

        load     = 1'b0;
        ld_data  = '0;
        ld_close = 1'b0;
        if (state == EMIT3) begin
            load     = out_free;
            ld_data  = p3;
            ld_close = p3_close;
        end else if (accept) begin
            load     = 1'b1;
            ld_close = in_stream_tlast;
            case (dec)
                PH1:     ld_data = {in_stream_tdata[15:0], carry[7:0]};
                PH2: begin
                    ld_data  = {in_stream_tdata[7:0], carry};
                    ld_close = 1'b0;
                end
                default: ld_data = in_stream_tdata[23:0];
            endcase
        end

        ld_x     = (accept && in_stream_tuser) ? '0 : nx;
        ld_y     = (accept && in_stream_tuser) ? '0 : ny;
        line_end = ld_close || (ld_x == X_LAST);

        // In PH2 the word's P3 is pixel W-1 exactly when P2 sits at W-2.
        tlast_err = accept && ((dec == PH2) ? (in_stream_tlast != (ld_x == X_PRE))
                                            : in_stream_tlast);
        sof_err   = accept && in_stream_tuser &&
                    !((state == PH0) && (nx == '0) && (ny == '0));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= PH0;
            carry      <= '0;
            p3         <= '0;
            p3_close   <= 1'b0;
            nx         <= '0;
            ny         <= '0;
            pix_valid  <= 1'b0;
            pix_r      <= '0;
            pix_g      <= '0;
            pix_b      <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            frame_done <= 1'b0;
            err_sof    <= 1'b0;
            err_line   <= 1'b0;
        end else begin
            frame_done <= pix_valid && pix_ready && (pix_x == X_LAST) && (pix_y == Y_LAST);

            if (load) begin
                pix_valid <= 1'b1;
                pix_r     <= COLOR_WIDTH'(ld_data[23:16]);
                pix_g     <= COLOR_WIDTH'(ld_data[15:8]);
                pix_b     <= COLOR_WIDTH'(ld_data[7:0]);
                pix_x     <= ld_x;
                pix_y     <= ld_y;
                pix_sof   <= (ld_x == '0) && (ld_y == '0);
                pix_eol   <= line_end;
                if (line_end) begin
                    nx <= '0;
                    ny <= (ld_y == Y_LAST) ? '0 : ld_y + 16'd1;
                end else begin
                    nx <= ld_x + 16'd1;
                    ny <= ld_y;
                end
            end else if (pix_ready) begin
                pix_valid <= 1'b0;
            end

            if (accept) begin
                case (dec)
                    PH1: begin
                        carry <= in_stream_tdata[31:16];
                        state <= in_stream_tlast ? PH0 : PH2;
                    end
                    PH2: begin
                        p3       <= in_stream_tdata[31:8];
                        p3_close <= in_stream_tlast;
                        state    <= EMIT3;
                    end
                    default: begin
                        carry <= {8'h00, in_stream_tdata[31:24]};
                        state <= in_stream_tlast ? PH0 : PH1;
                    end
                endcase
            end else if ((state == EMIT3) && out_free) begin
                state <= PH0;
            end

            if (tlast_err) err_line <= 1'b1;
            if (sof_err)   err_sof  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pixel_unpacker.sv
// Randomized bench for pixel_unpacker on an 8x2 grid: a byte-stream packer builds the words
// and a coordinate model predicts every emitted pixel.
module tb_pixel_unpacker;

    localparam int W = 8;
    localparam int H = 2;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] in_stream_tdata = '0;
    logic [3:0]  in_stream_tkeep = 4'hF;
    logic        in_stream_tlast = 1'b0;
    logic        in_stream_tuser = 1'b0;
    logic        in_stream_tvalid = 1'b0;
    logic        in_stream_tready;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic [15:0] pix_x, pix_y;
    logic        pix_sof, pix_eol, pix_valid;
    logic        pix_ready = 1'b1;
    logic        frame_done, err_sof, err_line;

    pixel_unpacker #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .COLOR_WIDTH(8)) dut (
        .aclk(aclk), .areset(areset),
        .in_stream_tdata(in_stream_tdata), .in_stream_tkeep(in_stream_tkeep),
        .in_stream_tlast(in_stream_tlast), .in_stream_tuser(in_stream_tuser),
        .in_stream_tvalid(in_stream_tvalid), .in_stream_tready(in_stream_tready),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_x(pix_x), .pix_y(pix_y),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_done(frame_done), .err_sof(err_sof), .err_line(err_line)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [23:0] d;
        logic [15:0] x;
        logic [15:0] y;
        logic        sof;
        logic        eol;
    } pix_t;

    pix_t        got[$];
    pix_t        exp_q[$];
    logic [23:0] pix_in[$];
    logic [31:0] words[$];
    bit          wu[$];
    bit          wl[$];
    int          total = 0;
    int          bad = 0;
    int          viol = 0;
    int          fd_cnt = 0;
    int          rdy_mode = 0;
    pix_t        mon_cur;
    pix_t        last_hold;
    bit          hold_prev = 1'b0;

    // 0: ready held high, 1: random ready, 2: ready held low
    always @(posedge aclk) begin
        #2;
        if (rdy_mode == 0)      pix_ready = 1'b1;
        else if (rdy_mode == 1) pix_ready = ($urandom_range(0, 3) != 0);
        else                    pix_ready = 1'b0;
    end

    // Output collector plus protocol watch: stalled outputs must hold, tready must respect a full register.
    always @(negedge aclk) begin
        mon_cur = {pix_r, pix_g, pix_b, pix_x, pix_y, pix_sof, pix_eol};
        if (!areset) begin
            if (hold_prev && (!pix_valid || mon_cur != last_hold)) viol++;
            if (in_stream_tready && pix_valid && !pix_ready) viol++;
            if (pix_valid && pix_ready) got.push_back(mon_cur);
            if (frame_done) fd_cnt++;
            hold_prev = pix_valid && !pix_ready;
            last_hold = mon_cur;
        end else begin
            if (in_stream_tready) viol++;
            hold_prev = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic do_reset();
        areset = 1'b1;
        in_stream_tvalid = 1'b0;
        rdy_mode = 0;
        repeat (2) @(posedge aclk);
        #1;
        areset = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input bit u, input bit l);
        int n;
        n = 0;
        in_stream_tdata  = d;
        in_stream_tuser  = u;
        in_stream_tlast  = l;
        in_stream_tvalid = 1'b1;
        @(negedge aclk);
        while (!in_stream_tready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        if (!in_stream_tready) begin
            total++; bad++;
            $display("FAIL send_timeout got tready=0 want=1");
        end
        @(posedge aclk);
        #1;
        in_stream_tvalid = 1'b0;
        in_stream_tuser  = 1'b0;
        in_stream_tlast  = 1'b0;
    endtask

    task automatic wait_pixels(input int n);
        for (int i = 0; i < 400 && got.size() < n; i++) @(negedge aclk);
        repeat (6) @(negedge aclk);
    endtask

    // Pixels become a little-endian byte stream (b,g,r per pixel), four bytes per word.
    function automatic void pack_words();
        logic [7:0] b[$];
        words.delete();
        foreach (pix_in[i]) begin
            b.push_back(pix_in[i][7:0]);
            b.push_back(pix_in[i][15:8]);
            b.push_back(pix_in[i][23:16]);
        end
        for (int k = 0; k < b.size() / 4; k++)
            words.push_back({b[4*k+3], b[4*k+2], b[4*k+1], b[4*k]});
    endfunction

    function automatic void set_framing();
        wu.delete();
        wl.delete();
        foreach (words[k]) begin
            wu.push_back((k % (3 * W * H / 4)) == 0);
            wl.push_back(((k + 1) % (3 * W / 4)) == 0);
        end
    endfunction

    function automatic void build_exp_frame();
        int x, y;
        exp_q.delete();
        foreach (pix_in[n]) begin
            x = n % W;
            y = (n / W) % H;
            exp_q.push_back({pix_in[n], 16'(x), 16'(y), (x == 0 && y == 0), (x == W - 1)});
        end
    endfunction

    function automatic void ramp_pixels();
        pix_in.delete();
        for (int n = 0; n < W * H; n++) pix_in.push_back(24'(24'h010203 * n));
    endfunction

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", pix_valid); end
        total++; if (in_stream_tready !== 1'b0) begin bad++; $display("FAIL rst_tready got=%b want=0", in_stream_tready); end
        total++; if ({err_sof, err_line, frame_done} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=000", {err_sof, err_line, frame_done}); end
        total++; if ({pix_x, pix_y, pix_r} !== 40'h0) begin bad++; $display("FAIL rst_data got=%h want=0", {pix_x, pix_y, pix_r}); end
        areset = 1'b0;
        #1;
        total++; if (in_stream_tready !== 1'b1) begin bad++; $display("FAIL rst_release_tready got=%b want=1", in_stream_tready); end
    endtask

    task automatic test_ramp_frame();
        int g0, f0, v0;
        do_reset();
        g0 = got.size(); f0 = fd_cnt; v0 = viol;
        ramp_pixels(); pack_words(); set_framing(); build_exp_frame();
        foreach (words[k]) send_word(words[k], wu[k], wl[k]);
        wait_pixels(g0 + exp_q.size());
        total++;
        if (got.size() - g0 != exp_q.size()) begin bad++; $display("FAIL ramp_count got=%0d want=%0d", got.size() - g0, exp_q.size()); end
        foreach (exp_q[i]) if (g0 + i < got.size()) begin
            total++;
            if (got[g0+i] !== exp_q[i]) begin
                bad++;
                $display("FAIL ramp_pix%0d got=%h/%0d/%0d/%b/%b want=%h/%0d/%0d/%b/%b", i,
                         got[g0+i].d, got[g0+i].x, got[g0+i].y, got[g0+i].sof, got[g0+i].eol,
                         exp_q[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].sof, exp_q[i].eol);
            end
        end
        total++; if (fd_cnt - f0 != 1) begin bad++; $display("FAIL ramp_frame_done got=%0d want=1", fd_cnt - f0); end
        total++; if ({err_sof, err_line} !== 2'b00) begin bad++; $display("FAIL ramp_errors got=%b want=00", {err_sof, err_line}); end
        total++; if (viol != v0) begin bad++; $display("FAIL ramp_protocol got=%0d want=%0d", viol, v0); end
    endtask

    task automatic test_backpressure();
        int g0, f0, v0;
        do_reset();
        rdy_mode = 1;
        g0 = got.size(); f0 = fd_cnt; v0 = viol;
        ramp_pixels(); pack_words(); set_framing(); build_exp_frame();
        foreach (words[k]) send_word(words[k], wu[k], wl[k]);
        wait_pixels(g0 + exp_q.size());
        total++;
        if (got.size() - g0 != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got.size() - g0, exp_q.size()); end
        foreach (exp_q[i]) if (g0 + i < got.size()) begin
            total++;
            if (got[g0+i] !== exp_q[i]) begin
                bad++;
                $display("FAIL bp_pix%0d got=%h/%0d/%0d/%b/%b want=%h/%0d/%0d/%b/%b", i,
                         got[g0+i].d, got[g0+i].x, got[g0+i].y, got[g0+i].sof, got[g0+i].eol,
                         exp_q[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].sof, exp_q[i].eol);
            end
        end
        total++; if (fd_cnt - f0 != 1) begin bad++; $display("FAIL bp_frame_done got=%0d want=1", fd_cnt - f0); end
        total++; if (viol != v0) begin bad++; $display("FAIL bp_protocol got=%0d want=%0d", viol, v0); end
        rdy_mode = 0;
    endtask

    task automatic test_known_words();
        int g0;
        logic [23:0] kexp[4];
        kexp = '{24'hBBCCDD, 24'h3344AA, 24'h881122, 24'h556677};
        do_reset();
        rdy_mode = 2;
        g0 = got.size();
        send_word(32'hAABBCCDD, 1'b1, 1'b0);
        total++; if (pix_valid !== 1'b1) begin bad++; $display("FAIL kw_latency got=%b want=1", pix_valid); end
        total++; if ({pix_r, pix_g, pix_b} !== 24'hBBCCDD) begin bad++; $display("FAIL kw_first got=%h want=bbccdd", {pix_r, pix_g, pix_b}); end
        total++; if (in_stream_tready !== 1'b0) begin bad++; $display("FAIL kw_full_tready got=%b want=0", in_stream_tready); end
        rdy_mode = 0;
        send_word(32'h11223344, 1'b0, 1'b0);
        send_word(32'h55667788, 1'b0, 1'b0);
        wait_pixels(g0 + 4);
        total++;
        if (got.size() - g0 != 4) begin bad++; $display("FAIL kw_count got=%0d want=4", got.size() - g0); end
        for (int i = 0; i < 4; i++) if (g0 + i < got.size()) begin
            total++;
            if (got[g0+i].d !== kexp[i]) begin bad++; $display("FAIL kw_pix%0d got=%h want=%h", i, got[g0+i].d, kexp[i]); end
        end
    endtask

    task automatic test_truncated_line();
        int g0;
        do_reset();
        g0 = got.size();
        pix_in.delete();
        for (int n = 0; n < W; n++) pix_in.push_back(24'($urandom));
        pack_words();
        exp_q.delete();
        for (int n = 0; n < W; n++)
            exp_q.push_back({pix_in[n], 16'(n % 4), 16'(n / 4), (n == 0), (n == 3)});
        for (int k = 0; k < 6; k++) send_word(words[k], (k == 0), (k == 2));
        wait_pixels(g0 + W);
        total++;
        if (got.size() - g0 != W) begin bad++; $display("FAIL trunc_count got=%0d want=%0d", got.size() - g0, W); end
        foreach (exp_q[i]) if (g0 + i < got.size()) begin
            total++;
            if (got[g0+i] !== exp_q[i]) begin
                bad++;
                $display("FAIL trunc_pix%0d got=%h/%0d/%0d/%b/%b want=%h/%0d/%0d/%b/%b", i,
                         got[g0+i].d, got[g0+i].x, got[g0+i].y, got[g0+i].sof, got[g0+i].eol,
                         exp_q[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].sof, exp_q[i].eol);
            end
        end
        total++; if ({err_sof, err_line} !== 2'b01) begin bad++; $display("FAIL trunc_errors got=%b want=01", {err_sof, err_line}); end
    endtask

    task automatic test_tuser_resync();
        int g0;
        do_reset();
        g0 = got.size();
        pix_in.delete();
        for (int n = 0; n < W; n++) pix_in.push_back(24'($urandom));
        pack_words();
        exp_q.delete();
        for (int n = 0; n < 5; n++)
            exp_q.push_back({pix_in[n], 16'(n), 16'd0, (n == 0), 1'b0});
        exp_q.push_back({words[4][23:0], 16'd0, 16'd0, 1'b1, 1'b0});
        for (int k = 0; k < 5; k++) send_word(words[k], (k == 0 || k == 4), 1'b0);
        wait_pixels(g0 + 6);
        total++;
        if (got.size() - g0 != 6) begin bad++; $display("FAIL sof_count got=%0d want=6", got.size() - g0); end
        foreach (exp_q[i]) if (g0 + i < got.size()) begin
            total++;
            if (got[g0+i] !== exp_q[i]) begin
                bad++;
                $display("FAIL sof_pix%0d got=%h/%0d/%0d/%b/%b want=%h/%0d/%0d/%b/%b", i,
                         got[g0+i].d, got[g0+i].x, got[g0+i].y, got[g0+i].sof, got[g0+i].eol,
                         exp_q[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].sof, exp_q[i].eol);
            end
        end
        total++; if ({err_sof, err_line} !== 2'b10) begin bad++; $display("FAIL sof_errors got=%b want=10", {err_sof, err_line}); end
    endtask

    task automatic test_reset_in_emit3();
        int g0, f0;
        do_reset();
        send_word($urandom, 1'b1, 1'b0);
        send_word($urandom, 1'b0, 1'b1);
        send_word($urandom, 1'b0, 1'b0);
        send_word($urandom, 1'b0, 1'b0);
        send_word($urandom, 1'b0, 1'b0);
        rdy_mode = 2;
        areset = 1'b1;
        total++; if ({pix_valid, err_line} !== 2'b11) begin bad++; $display("FAIL emit3_pre got=%b want=11", {pix_valid, err_line}); end
        @(posedge aclk);
        #1;
        total++; if ({pix_valid, in_stream_tready} !== 2'b00) begin bad++; $display("FAIL emit3_rst got=%b want=00", {pix_valid, in_stream_tready}); end
        total++; if ({err_sof, err_line} !== 2'b00) begin bad++; $display("FAIL emit3_rst_err got=%b want=00", {err_sof, err_line}); end
        total++; if ({pix_r, pix_g, pix_b, pix_x, pix_y} !== 56'h0) begin bad++; $display("FAIL emit3_rst_data got=%h want=0", {pix_r, pix_g, pix_b, pix_x, pix_y}); end
        areset = 1'b0;
        rdy_mode = 0;
        g0 = got.size(); f0 = fd_cnt;
        ramp_pixels(); pack_words(); set_framing(); build_exp_frame();
        foreach (words[k]) send_word(words[k], wu[k], wl[k]);
        wait_pixels(g0 + exp_q.size());
        total++;
        if (got.size() - g0 != exp_q.size()) begin bad++; $display("FAIL emit3_count got=%0d want=%0d", got.size() - g0, exp_q.size()); end
        foreach (exp_q[i]) if (g0 + i < got.size()) begin
            total++;
            if (got[g0+i] !== exp_q[i]) begin
                bad++;
                $display("FAIL emit3_pix%0d got=%h/%0d/%0d/%b/%b want=%h/%0d/%0d/%b/%b", i,
                         got[g0+i].d, got[g0+i].x, got[g0+i].y, got[g0+i].sof, got[g0+i].eol,
                         exp_q[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].sof, exp_q[i].eol);
            end
        end
        total++; if (fd_cnt - f0 != 1) begin bad++; $display("FAIL emit3_frame_done got=%0d want=1", fd_cnt - f0); end
        total++; if ({err_sof, err_line} !== 2'b00) begin bad++; $display("FAIL emit3_errors got=%b want=00", {err_sof, err_line}); end
    endtask

    task automatic test_back_to_back();
        int g0, f0, v0;
        do_reset();
        rdy_mode = 1;
        g0 = got.size(); f0 = fd_cnt; v0 = viol;
        pix_in.delete();
        for (int n = 0; n < 2 * W * H; n++) pix_in.push_back(24'($urandom));
        pack_words(); set_framing(); build_exp_frame();
        foreach (words[k]) send_word(words[k], wu[k], wl[k]);
        wait_pixels(g0 + exp_q.size());
        total++;
        if (got.size() - g0 != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", got.size() - g0, exp_q.size()); end
        foreach (exp_q[i]) if (g0 + i < got.size()) begin
            total++;
            if (got[g0+i] !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_pix%0d got=%h/%0d/%0d/%b/%b want=%h/%0d/%0d/%b/%b", i,
                         got[g0+i].d, got[g0+i].x, got[g0+i].y, got[g0+i].sof, got[g0+i].eol,
                         exp_q[i].d, exp_q[i].x, exp_q[i].y, exp_q[i].sof, exp_q[i].eol);
            end
        end
        total++; if (fd_cnt - f0 != 2) begin bad++; $display("FAIL b2b_frame_done got=%0d want=2", fd_cnt - f0); end
        total++; if ({err_sof, err_line} !== 2'b00) begin bad++; $display("FAIL b2b_errors got=%b want=00", {err_sof, err_line}); end
        total++; if (viol != v0) begin bad++; $display("FAIL b2b_protocol got=%0d want=%0d", viol, v0); end
        rdy_mode = 0;
    endtask

    initial begin
        test_reset();
        test_ramp_frame();
        test_backpressure();
        test_known_words();
        test_truncated_line();
        test_tuser_resync();
        test_reset_in_emit3();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
